// File: rtl/bin_to_bcd_seq.sv
// bin_to_bcd_seq: sequential binary-to-BCD converter (double-dabble) for the
// calculator result path. Accepts an unsigned or two's-complement operand,
// produces BCD digits, a sign flag and active-low 7-segment patterns for a
// four-digit display.
//
// Handshake: a request is accepted on a rising edge where start=1 and the
// engine is idle; busy is high from that edge until the completion edge,
// where done pulses for exactly one cycle. start while busy is dropped.
// start in the done cycle is accepted (the engine is already idle).
module bin_to_bcd_seq #(
  parameter int WIDTH  = 8,
  parameter int DIGITS = 3
) (
  input  logic                  CLK,
  input  logic                  reset,
  input  logic                  start,
  input  logic                  signed_mode,
  input  logic [WIDTH-1:0]      bin_in,
  output logic                  busy,
  output logic                  done,
  output logic                  neg,
  output logic [4*DIGITS-1:0]   bcd,
  output logic [0:6]            hex0,
  output logic [0:6]            hex1,
  output logic [0:6]            hex2,
  output logic [0:6]            hex3,
  output logic                  state_dbg
);

  localparam int CW = $clog2(WIDTH + 1);

  localparam logic [0:6] SEG_BLANK = 7'b1111111;
  localparam logic [0:6] SEG_MINUS = 7'b1111110;
  localparam logic [0:6] SEG_ZERO  = 7'b0000001;

  typedef enum logic {IDLE = 1'b0, SHIFT = 1'b1} state_t;

  state_t              state;
  logic [CW-1:0]       count;
  logic [4*DIGITS-1:0] scr;       // BCD scratch, never visible on outputs
  logic [WIDTH-1:0]    mag;       // magnitude being shifted out
  logic                neg_pend;  // sign of the conversion in flight

  logic [4*DIGITS-1:0] adj;
  logic [4*DIGITS-1:0] next_scr;
  logic [WIDTH-1:0]    next_mag;
  logic [3:0]          dig0, dig1, dig2;

  assign state_dbg = state;

  // Active-low a..g glyph for one decimal digit.
  function automatic logic [0:6] seg7(input logic [3:0] d);
    logic [0:6] s;
    case (d)
      4'd0:    s = 7'b0000001;
      4'd1:    s = 7'b1001111;
      4'd2:    s = 7'b0010010;
      4'd3:    s = 7'b0000110;
      4'd4:    s = 7'b1001100;
      4'd5:    s = 7'b0100100;
      4'd6:    s = 7'b0100000;
      4'd7:    s = 7'b0001111;
      4'd8:    s = 7'b0000000;
      4'd9:    s = 7'b0000100;
      default: s = SEG_BLANK;
    endcase
    return s;
  endfunction

  // One double-dabble iteration: add 3 to every nibble >= 5, then shift
  // the combined {BCD, magnitude} register left by one bit.
  always_comb begin
    adj = scr;
    for (int d = 0; d < DIGITS; d++) begin
      if (scr[4*d +: 4] >= 4'd5) adj[4*d +: 4] = scr[4*d +: 4] + 4'd3;
    end
    next_scr = {adj[4*DIGITS-2:0], mag[WIDTH-1]};
    next_mag = {mag[WIDTH-2:0], 1'b0};
    // Display digits are taken from the final iteration result; the
    // display supports up to three digits.
    dig0 = next_scr[3:0];
    dig1 = next_scr[7:4];
    dig2 = next_scr[11:8];
  end

  // Control FSM, conversion datapath and registered display outputs.
  always_ff @(posedge CLK or posedge reset) begin
    if (reset) begin
      state    <= IDLE;
      count    <= '0;
      scr      <= '0;
      mag      <= '0;
      neg_pend <= 1'b0;
      busy     <= 1'b0;
      done     <= 1'b0;
      neg      <= 1'b0;
      bcd      <= '0;
      hex0     <= SEG_ZERO;
      hex1     <= SEG_BLANK;
      hex2     <= SEG_BLANK;
      hex3     <= SEG_BLANK;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            // Negating 8'h80 yields 8'h80, which read unsigned is 128.
            if (signed_mode && bin_in[WIDTH-1]) begin
              mag      <= ~bin_in + 1'b1;
              neg_pend <= 1'b1;
            end else begin
              mag      <= bin_in;
              neg_pend <= 1'b0;
            end
            scr   <= '0;
            count <= '0;
            busy  <= 1'b1;
            state <= SHIFT;
          end
        end
        SHIFT: begin
          scr   <= next_scr;
          mag   <= next_mag;
          count <= count + 1'b1;
          if (count == CW'(WIDTH - 1)) begin
            bcd   <= next_scr;
            neg   <= neg_pend;
            hex0  <= seg7(dig0);
            hex1  <= (dig2 == 4'd0 && dig1 == 4'd0) ? SEG_BLANK : seg7(dig1);
            hex2  <= (dig2 == 4'd0) ? SEG_BLANK : seg7(dig2);
            hex3  <= neg_pend ? SEG_MINUS : SEG_BLANK;
            busy  <= 1'b0;
            done  <= 1'b1;
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
